// File: rtl/exe_mem_pipe_reg_pkg.sv
// ============================================================================
// Module  : exe_mem_pipe_reg_pkg
// Purpose : Shared definitions for the EXE->MEM stage register. These are the
//           default widths, the payload bundle field order, the occupancy
//           state encoding and a payload width helper.
// Ports   : none (package)
// Config  : EXE_MEM_SKID_EN selects the two-entry skid build. It is used by
//           exe_mem_pipe_reg.
// Revision: 1.0 - initial elastic stage register
// ============================================================================
`default_nettype none

package exe_mem_pipe_reg_pkg;

  localparam int WORD_WIDTH_DEF  = 32;
  localparam int REG_ADDR_W_DEF  = 4;
  localparam int REG_FILE_DEPTH  = 16;

  // Canonical field order for every stage register carrying this payload.
  // The flat vectors in exe_mem_pipe_reg are packed in exactly this order.
  typedef struct packed {
    logic [WORD_WIDTH_DEF-1:0] pc;
    logic [WORD_WIDTH_DEF-1:0] instruction;
    logic [REG_ADDR_W_DEF-1:0] dst;
    logic [WORD_WIDTH_DEF-1:0] alu_res;
    logic [WORD_WIDTH_DEF-1:0] val_rm;
    logic                      mem_read;
    logic                      mem_write;
    logic                      wb_en;
  } exe_mem_payload_t;

  // Occupancy of the stage. OCC_TWO exists only in the skid build.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_t;

  // Flat payload width for arbitrary word and register-index widths.
  function automatic int payload_width(input int word_w, input int reg_w);
    return 4 * word_w + reg_w + 3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/exe_mem_pipe_reg_skid_slot.sv
// ============================================================================
// Module  : pipe_skid_slot
// Purpose : One payload register with load enable and valid bit.
//           It holds one stage entry.
// Ports   : clk, rst_n (sync active-low), clr (invalidate, data kept),
//           load (capture data_in, set valid), drop (clear valid),
//           data_in/data_out (WIDTH), valid
// Config  : none
// Revision: 1.0 - initial
// ============================================================================
`default_nettype none

module pipe_skid_slot
  import exe_mem_pipe_reg_pkg::*;
#(
  parameter int WIDTH = payload_width(WORD_WIDTH_DEF, REG_ADDR_W_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             drop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid
);

  // A clear only invalidates the entry. The data keeps its last value, so the
  // outputs never go X. A load with a drop in the same cycle means the entry
  // was consumed and replaced, so load wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out <= '0;
      valid    <= 1'b0;
    end else if (clr) begin
      valid    <= 1'b0;
    end else if (load) begin
      data_out <= data_in;
      valid    <= 1'b1;
    end else if (drop) begin
      valid    <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/exe_mem_pipe_reg.sv
// ============================================================================
// Module  : exe_mem_pipe_reg
// Purpose : Elastic EXE->MEM pipeline register with a valid/ready handshake,
//           synchronous flush and qualified control outputs. It also exports
//           the held write-back enable to the hazard unit.
// Ports   : clk, rst_n (sync active-low), flush
//           in_valid/in_ready + pc/instruction/alu_res/val_rm/dst/ctrl inputs
//           out_valid/out_ready + matching outputs, fwd_wb_en
// Config  : EXE_MEM_SKID_EN defined -> two-entry skid buffer with registered
//           in_ready. Undefined -> single entry, in_ready = !out_valid|out_ready.
// Revision: 1.0 - replaces the fixed always-load stage register
// ============================================================================
`default_nettype none

module exe_mem_pipe_reg
  import exe_mem_pipe_reg_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] pc_in,
  input  logic [WORD_WIDTH-1:0] instruction_in,
  input  logic [WORD_WIDTH-1:0] alu_res_in,
  input  logic [WORD_WIDTH-1:0] val_rm_in,
  input  logic [REG_ADDR_W-1:0] dst_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  wb_en_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] pc_out,
  output logic [WORD_WIDTH-1:0] instruction_out,
  output logic [WORD_WIDTH-1:0] alu_res_out,
  output logic [WORD_WIDTH-1:0] val_rm_out,
  output logic [REG_ADDR_W-1:0] dst_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic                  wb_en_out,
  output logic                  fwd_wb_en
);

  localparam int PW = payload_width(WORD_WIDTH, REG_ADDR_W);

  logic [PW-1:0] in_payload;
  logic [PW-1:0] head_d;
  logic [PW-1:0] head_q;
  logic          head_valid;
  logic          head_load;
  logic          in_xfer;
  logic          out_xfer;
  logic          head_mem_read;
  logic          head_mem_write;
  logic          head_wb_en;

  assign in_payload = {pc_in, instruction_in, dst_in, alu_res_in, val_rm_in,
                       mem_read_in, mem_write_in, wb_en_in};

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = head_valid & out_ready;

`ifdef EXE_MEM_SKID_EN
  logic [PW-1:0] skid_q;
  logic          skid_valid;
  logic          skid_load;
  occ_state_t    state;
  logic          in_ready_q;

  // The head refills from the skid entry when one is waiting. Otherwise it
  // refills from EXE, either when the head is empty or when it drains in the
  // same cycle.
  assign head_load = (in_xfer & (~head_valid | out_xfer)) | (out_xfer & skid_valid);
  assign head_d    = skid_valid ? skid_q : in_payload;
  // A new entry parks in the skid slot only while the head is stalled.
  assign skid_load = in_xfer & head_valid & ~out_xfer;

  pipe_skid_slot #(.WIDTH(PW)) u_skid_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .load     (skid_load),
    .drop     (out_xfer),
    .data_in  (in_payload),
    .data_out (skid_q),
    .valid    (skid_valid)
  );

  // in_ready is registered from the next occupancy. This keeps the MEM-side
  // ready off the EXE/hazard timing path.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state      <= OCC_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      unique case (state)
        OCC_EMPTY: begin
          if (in_xfer) state <= OCC_ONE;
          in_ready_q <= 1'b1;
        end
        OCC_ONE: begin
          if (in_xfer && !out_xfer) begin
            state      <= OCC_TWO;
            in_ready_q <= 1'b0;
          end else begin
            if (!in_xfer && out_xfer) state <= OCC_EMPTY;
            in_ready_q <= 1'b1;
          end
        end
        OCC_TWO: begin
          if (out_xfer) begin
            state      <= OCC_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= OCC_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
`else
  assign head_load = in_xfer;
  assign head_d    = in_payload;
  assign in_ready  = ~head_valid | out_ready;
`endif

  pipe_skid_slot #(.WIDTH(PW)) u_head_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .load     (head_load),
    .drop     (out_xfer),
    .data_in  (head_d),
    .data_out (head_q),
    .valid    (head_valid)
  );

  assign {pc_out, instruction_out, dst_out, alu_res_out, val_rm_out,
          head_mem_read, head_mem_write, head_wb_en} = head_q;

  // Stale control bits must never reach MEM or the hazard unit.
  assign out_valid     = head_valid;
  assign mem_read_out  = head_mem_read  & head_valid;
  assign mem_write_out = head_mem_write & head_valid;
  assign wb_en_out     = head_wb_en     & head_valid;
  assign fwd_wb_en     = wb_en_out;

endmodule

`default_nettype wire
